plaintext_checker: RTL

//  Downstream of the RC4 decryption stage: consumes the decrypted keystream-XOR byte stream for
//  one candidate secret key, writes each byte into the result RAM, and judges the plaintext.
//  Any byte outside 'a'..'z' or space rejects the key at once (pulse advances the secret

---
 rtl/plaintext_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/plaintext_checker.sv
// plaintext_checker: judges one decrypted RC4 message per candidate key.
// Writes every accepted byte to the result RAM and flags reject/found.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          pulse: begin (or restart) checking a new candidate key
//   in_valid       in_data carries a decrypted byte
//   in_data        decrypted byte, message order 0..MSG_LEN-1
//   in_ready       byte accepted this cycle when in_valid is also high
//   ram_address    result RAM write address (registered)
//   ram_data       result RAM write data (registered)
//   ram_wren       result RAM write enable, one pulse per accepted byte
//   key_reject     pulse: current key produced an illegal byte
//   key_found      level: whole message legal; held until reset or start
//   done           pulse: a verdict (reject or found) was reached
//   busy           checker is consuming a message
module plaintext_checker #(
   parameter int         MSG_LEN = 32,
   parameter int         ADDR_W  = 5,
   parameter logic [7:0] LO_CHAR = 8'h61,
   parameter logic [7:0] HI_CHAR = 8'h7A,
   parameter logic [7:0] SPACE   = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic [7:0]        ram_data,
   output logic              ram_wren,
   output logic              key_reject,
   output logic              key_found,
   output logic              done,
   output logic              busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic              found_nxt, reject_nxt, done_nxt;
   logic              xfer, legal;

   assign busy = (state == RUN);

   // A start cycle never accepts a byte: the byte belongs to no key yet.
   assign in_ready = busy && !start && !reset;
   assign xfer     = in_valid && in_ready;

   assign legal = ((in_data >= LO_CHAR) && (in_data <= HI_CHAR))
                  || (in_data == SPACE);

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      found_nxt  = key_found;
      reject_nxt = 1'b0;
      done_nxt   = 1'b0;
      if (start) begin
         state_nxt = RUN;
         idx_nxt   = '0;
         found_nxt = 1'b0;
      end else if (xfer) begin
         if (!legal) begin
            state_nxt  = IDLE;
            reject_nxt = 1'b1;
            done_nxt   = 1'b1;
         end else if (idx == LAST) begin
            state_nxt = IDLE;
            found_nxt = 1'b1;
            done_nxt  = 1'b1;
         end else begin
            idx_nxt = idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
         key_reject  <= 1'b0;
         key_found   <= 1'b0;
         done        <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         ram_wren   <= xfer;
         key_reject <= reject_nxt;
         key_found  <= found_nxt;
         done       <= done_nxt;
         // Illegal bytes are written too, so the RAM shows what failed.
         if (xfer) begin
            ram_address <= idx;
            ram_data    <= in_data;
         end
      end
   end

endmodule
